// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: MEM-stage data-memory unit. Splits one 32-bit load/store into two 16-bit
// accesses on an external asynchronous SRAM, holding each half on the bus for WAIT_CYCLES cycles.
// While an access is in flight, ready is low; the pipeline freezes on ~ready.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   rd_en, wr_en        load / store request (wr_en wins if both set), held until ready
//   addr, wdata         CPU byte address and store data
//   rdata               load result, valid from DONE until the next read overwrites it
//   ready               no request pending, or request completing this cycle
//   err                 one-cycle address-fault pulse (only with MEM_ADDR_CHECK_EN)
//   sram_addr           SRAM halfword address
//   sram_dq_o/_i/_oe    SRAM data out / in / output enable (tristate built at top level)
//   sram_we_n           SRAM write enable, active low
//
// Optional feature: define MEM_ADDR_CHECK_EN to fault requests that are below BASE_ADDR,
// misaligned, or beyond the SRAM; they skip the SRAM and finish in DONE with err=1.

module mem_sram_ctrl #(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              err,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_o,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_we_n
);

    localparam int unsigned    CntW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-2:0] widx_q, widx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       offset;
    logic              cnt_last;

    assign offset   = addr - BASE_ADDR;
    assign cnt_last = (cnt_q == CntLast);
    assign rdata    = rdata_q;

`ifdef MEM_ADDR_CHECK_EN
    localparam logic [32:0] HalfLimit = 33'd1 << ADDR_W;

    logic fault;
    logic err_q, err_d;

    assign fault = (addr < BASE_ADDR) || (addr[1:0] != 2'b00) ||
                   ({2'b00, offset[31:1]} >= HalfLimit);
    assign err   = err_q;
`else
    // Without the check, high offset bits are simply dropped (address wraps in SRAM).
    logic unused_offset;
    assign unused_offset = ^{offset[31:ADDR_W+1], offset[1:0]};
    assign err           = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_wr_d    = is_wr_q;
        widx_d     = widx_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
`ifdef MEM_ADDR_CHECK_EN
        err_d      = 1'b0;
`endif
        ready      = 1'b0;
        sram_addr  = '0;
        sram_dq_o  = '0;
        sram_dq_oe = 1'b0;
        sram_we_n  = 1'b1;

        unique case (state_q)
            StIdle: begin
                ready = !(rd_en || wr_en);
                if (rd_en || wr_en) begin
                    // Latch everything now; inputs may change once we leave IDLE.
                    is_wr_d = wr_en;
                    widx_d  = offset[ADDR_W:2];
                    wdata_d = wdata;
                    cnt_d   = '0;
                    state_d = StLo;
`ifdef MEM_ADDR_CHECK_EN
                    if (fault) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                        if (!wr_en) begin
                            rdata_d = '0;
                        end
                    end
`endif
                end
            end

            StLo: begin
                sram_addr = {widx_q, 1'b0};
                if (is_wr_q) begin
                    sram_we_n  = 1'b0;
                    sram_dq_oe = 1'b1;
                    sram_dq_o  = wdata_q[15:0];
                end
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = StHi;
                    // Sample at the end of the hold window so SRAM access time is met.
                    if (!is_wr_q) begin
                        rdata_d[15:0] = sram_dq_i;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StHi: begin
                sram_addr = {widx_q, 1'b1};
                if (is_wr_q) begin
                    sram_we_n  = 1'b0;
                    sram_dq_oe = 1'b1;
                    sram_dq_o  = wdata_q[31:16];
                end
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = StDone;
                    if (!is_wr_q) begin
                        rdata_d[31:16] = sram_dq_i;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StDone: begin
                ready   = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            widx_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_ADDR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MEM_ADDR_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Testbench for mem_sram_ctrl: directed and randomized accesses against a word-level
// reference memory, with a halfword SRAM model attached to the bus.

module tb_mem_sram_ctrl;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned WAIT   = 5;
    localparam logic [31:0] BASE   = 32'd1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_en, wr_en;
    logic [31:0]       addr, wdata, rdata;
    logic              ready, err;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_o, sram_dq_i;
    logic              sram_dq_oe, sram_we_n;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [int unsigned];
    logic [31:0] model_rdata = 32'h0;

    logic [15:0] sram [0:(1<<ADDR_W)-1];

    mem_sram_ctrl #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .err        (err),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    assign sram_dq_i = sram[sram_addr];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            sram[sram_addr] <= sram_dq_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fault(input logic [31:0] a);
`ifdef MEM_ADDR_CHECK_EN
        logic [31:0] diff;
        diff = a - BASE;
        return (a < BASE) || (a % 4 != 0) || ((diff / 2) >= (32'd1 << ADDR_W));
`else
        return (a != a);
`endif
    endfunction

    // One request from IDLE through DONE; inputs are left asserted afterwards.
    task automatic access(input bit w, input bit r, input logic [31:0] a,
                          input logic [31:0] d, input int drop_at);
        logic [31:0]       diff;
        logic [ADDR_W-2:0] widx;
        logic [ADDR_W-1:0] exp_sa;
        logic [15:0]       exp_dq;
        logic [31:0]       exp_rd;
        bit                flt, half, done;
        int                exp_lat, lat;

        diff    = a - BASE;
        widx    = (ADDR_W-1)'(diff / 4);
        flt     = is_fault(a);
        exp_lat = flt ? 1 : 2 * WAIT + 1;
        if (flt) begin
            exp_rd = w ? model_rdata : 32'h0;
        end else if (w) begin
            exp_rd       = model_rdata;
            ref_mem[widx] = d;
        end else begin
            exp_rd = ref_mem.exists(widx) ? ref_mem[widx] : 32'h0;
        end
        model_rdata = exp_rd;

        @(negedge clk);
        wr_en = w;
        rd_en = r;
        addr  = a;
        wdata = d;
        #1;
        chk("req_ready", 32'(ready), 32'd0);

        lat  = 0;
        done = 1'b0;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            if (drop_at != 0 && k == drop_at) begin
                rd_en = 1'b0;
                wr_en = 1'b0;
                addr  = $urandom;
                wdata = $urandom;
            end
            #1;
            if (ready) begin
                done = 1'b1;
                lat  = k;
            end else if (k <= 2 * WAIT) begin
                half   = (k > WAIT);
                exp_sa = ADDR_W'(widx) * 2 + ADDR_W'(half);
                exp_dq = w ? (half ? d[31:16] : d[15:0]) : 16'h0;
                chk("sram_addr", 32'(sram_addr), 32'(exp_sa));
                chk("sram_we_n", 32'(sram_we_n), 32'(!w));
                chk("sram_dq_oe", 32'(sram_dq_oe), 32'(w));
                chk("sram_dq_o", 32'(sram_dq_o), 32'(exp_dq));
                chk("err_busy", 32'(err), 32'd0);
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        if (done) begin
            chk("rdata", rdata, exp_rd);
            chk("err_done", 32'(err), 32'(flt));
            chk("done_we_n", 32'(sram_we_n), 32'd1);
            chk("done_oe", 32'(sram_dq_oe), 32'd0);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        rd_en = 1'b0;
        wr_en = 1'b0;
        #1;
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_rdata", rdata, model_rdata);
    endtask

    initial begin
        int op, idx, drop;
        logic [31:0] a;

        rst   = 1'b1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // Basic write then read of word 0.
        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 0);
        go_idle();
        access(1'b0, 1'b1, 32'd1024, 32'h0, 0);
        go_idle();

        // Back-to-back write then read, no idle cycle between.
        access(1'b1, 1'b0, 32'd1028, 32'h12345678, 0);
        access(1'b0, 1'b1, 32'd1028, 32'h0, 0);

        // Both requests set: write wins, rdata untouched.
        access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 0);
        go_idle();
        access(1'b0, 1'b1, 32'd1032, 32'h0, 0);

        // Request dropped mid-access still runs to completion.
        access(1'b0, 1'b1, 32'd1028, 32'h0, 4);
        go_idle();

        // Reset in cycle 3 of a read.
        @(negedge clk);
        rd_en = 1'b1;
        addr  = 32'd1024;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        rd_en = 1'b0;
        #1;
        model_rdata = 32'h0;
        chk("rstmid_ready", 32'(ready), 32'd1);
        chk("rstmid_rdata", rdata, 32'h0);
        chk("rstmid_we_n", 32'(sram_we_n), 32'd1);
        chk("rstmid_oe", 32'(sram_dq_oe), 32'd0);
        chk("rstmid_addr", 32'(sram_addr), 32'd0);
        access(1'b0, 1'b1, 32'd1024, 32'h0, 0);
        go_idle();

        // Misaligned / out-of-range addresses (fault with the check, alias without).
        access(1'b1, 1'b0, 32'd1026, 32'hA5A55A5A, 0);
        access(1'b0, 1'b1, 32'd1026, 32'h0, 0);
`ifdef MEM_ADDR_CHECK_EN
        access(1'b0, 1'b1, 32'd512, 32'h0, 0);
        access(1'b1, 1'b0, BASE + (32'd1 << (ADDR_W + 1)), 32'h11112222, 0);
        access(1'b0, 1'b1, BASE + (32'd1 << (ADDR_W + 1)) - 32'd4, 32'h0, 0);
`endif
        go_idle();

        // Randomized: prefill 8 words, then a mix of reads, writes and both.
        for (int i = 0; i < 8; i++) begin
            access(1'b1, 1'b0, BASE + 32'(4 * i), $urandom, 0);
        end
        for (int i = 0; i < 24; i++) begin
            op  = $urandom_range(0, 2);
            idx = $urandom_range(0, 7);
            a   = BASE + 32'(4 * idx);
`ifdef MEM_ADDR_CHECK_EN
            if ($urandom_range(0, 4) == 0) begin
                a = ($urandom_range(0, 1) == 0) ? a + 32'($urandom_range(1, 3)) : BASE - 32'd4;
            end
`endif
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0;
            access(op != 1, op != 0, a, $urandom, drop);
            if ($urandom_range(0, 1) == 1) begin
                go_idle();
            end
        end
        go_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
